gpio_port_controller: RTL and testbench
=======================================

Name: gpio_port_controller

Overview:
Command front-end for a bank of GPIO cells. Accepts single-beat commands over a valid/ready handshake and decodes them into one-cycle per-cell Set/Clear/PulseInit strobes with a shared 10-bit data bus. Reads back pin and driven-output state, and keeps sticky rising-edge latches on the synchronized pin inputs. Sits between the I/O register interface and the per-pin output cells.

Parameters:
CELL_COUNT, 8, number of GPIO cells driven (1..16)
INDEX_W, 4, width of cell index field; must satisfy 2**INDEX_W >= CELL_COUNT

Ports:
clk  in  1  clock
sync_rst  in  1  synchronous active-high reset
clk_en  in  1  global clock enable; all state advances only when high (sync_rst overrides)
CmdValid  in  1  command offered
CmdReady  out  1  controller can accept a command
CmdOp  in  3  0=DRIVE, 1=RELEASE, 2=PULSE, 3=READ_PINS, 4=READ_OUTS, 5=READ_EDGES; 6,7 reserved
CmdIndex  in  INDEX_W  target cell (ops 0-2)
CmdData  in  10  DRIVE: bit0 = level; PULSE: length in clk_en cycles
RespValid  out  1  response available
RespReady  in  1  response consumed
RespData  out  16  read data, zero-extended, cell i at bit i; 0 for ops 0-2
RespErr  out  1  command rejected; no strobe issued
CellSet  out  CELL_COUNT  per-cell set strobe
CellClear  out  CELL_COUNT  per-cell clear strobe
CellPulseInit  out  CELL_COUNT  per-cell pulse-start strobe
CellDataIn  out  10  shared data to all cells
CellLocalDataOut  in  CELL_COUNT  driven level per cell
CellPinDataOut  in  CELL_COUNT  registered pin level per cell

Behaviour:
- Every register updates only when clk_en=1 or sync_rst=1; sync_rst wins.
- Reset: state=IDLE; CmdReady=0 during reset, 1 afterwards; RespValid=0, RespData=0, RespErr=0; all Cell* strobes=0; CellDataIn=0; edge latches=0; pin-history register=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: CmdReady=1. Accept on CmdValid&CmdReady&clk_en. Latch the op, index and data, then go to ISSUE.
- ISSUE: lasts exactly one clk_en cycle; CmdReady=0.
  - DRIVE: CellSet[idx]=1 and CellDataIn={9'b0,level}.
  - RELEASE: CellClear[idx]=1.
  - PULSE: CellPulseInit[idx]=1 and CellDataIn=length.
  - Read ops: no strobes. RespData is captured at the end of this cycle.
  - Then go to RESP.
- Strobes are registered outputs. They are high only during ISSUE and are one-hot (at most one bit across all three vectors).
- CellDataIn holds its last value outside ISSUE.
- Errors: idx>=CELL_COUNT on ops 0-2, op 6/7, or PULSE with length 0. On error, no strobe in ISSUE, and RespErr=1 with RespData=0.
- RESP: RespValid=1; RespData/RespErr are stable until RespReady&clk_en, then return to IDLE with RespValid=0.
- Command latency: accepted at edge T, strobe visible T+1 to T+2, RespValid asserted from T+2. Next command can be accepted at the earliest in the cycle after the response handshake (3 clk_en cycles/command minimum).
- READ_PINS returns CellPinDataOut. READ_OUTS returns CellLocalDataOut. Both are sampled in ISSUE.
- Edge latches:
  - Each clk_en cycle: hist<=CellPinDataOut; edge[i] set when hist[i]=0 and CellPinDataOut[i]=1.
  - READ_EDGES returns edge in RespData and clears the latch in that same ISSUE cycle.
  - A new edge detected in that same cycle wins: the latch stays 1 and is reported on the next read.
- clk_en=0 during any state freezes all outputs and state.
- sync_rst mid-command aborts it: no pending strobe or response survives.

Test Plan:
- Reset, then DRIVE idx=3 data=1 -> CellSet=8'h08 for one clk_en cycle with CellDataIn=10'h001; RespValid with RespData=0, RespErr=0; CmdReady low until the response handshake.
- PULSE idx=0 data=10'd5, then RELEASE idx=7 back-to-back -> CellPulseInit=8'h01 with CellDataIn=5; later CellClear=8'h80; exactly two responses, in order.
- Errors: DRIVE idx=9 (CELL_COUNT=8), op=6, PULSE length 0 -> each gives RespErr=1, RespData=0, and no strobe on any vector.
- CellPinDataOut 0->8'h05, then READ_EDGES -> RespData=16'h0005; an immediate second READ_EDGES -> 0. Raise bit 1 exactly in the clearing ISSUE cycle -> the next READ_EDGES returns 16'h0002.
- Hold RespReady=0 for 10 cycles and toggle clk_en 0/1 during ISSUE -> RespData stable, no duplicate strobes, strobe width = one clk_en-qualified cycle.
- Assert sync_rst while in ISSUE and while in RESP -> all strobes, RespValid and edge latches read 0 on the next cycle; CmdReady=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/gpio_port_controller_if.sv
// Command/response handshake bundle for the GPIO port controller.
// Master issues commands and consumes responses; slave is the controller.
interface gpio_port_controller_if #(
   parameter int INDEX_W = 4
) ();
   logic               CmdValid;
   logic               CmdReady;
   logic [2:0]         CmdOp;
   logic [INDEX_W-1:0] CmdIndex;
   logic [9:0]         CmdData;
   logic               RespValid;
   logic               RespReady;
   logic [15:0]        RespData;
   logic               RespErr;

   modport master (
      output CmdValid, CmdOp, CmdIndex, CmdData, RespReady,
      input  CmdReady, RespValid, RespData, RespErr
   );

   modport slave (
      input  CmdValid, CmdOp, CmdIndex, CmdData, RespReady,
      output CmdReady, RespValid, RespData, RespErr
   );
endinterface

// File: rtl/gpio_port_controller.sv
// GPIO port controller: decodes single-beat commands into per-cell
// strobes, reads back pin/output state and sticky rising-edge latches.
module gpio_port_controller #(
   parameter int CELL_COUNT = 8,
   parameter int INDEX_W    = 4
) (
   input  logic                  clk,
   input  logic                  sync_rst,
   input  logic                  clk_en,
   gpio_port_controller_if.slave bus,
   output logic [CELL_COUNT-1:0] CellSet,
   output logic [CELL_COUNT-1:0] CellClear,
   output logic [CELL_COUNT-1:0] CellPulseInit,
   output logic [9:0]            CellDataIn,
   input  logic [CELL_COUNT-1:0] CellLocalDataOut,
   input  logic [CELL_COUNT-1:0] CellPinDataOut
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   localparam logic [2:0] OP_DRIVE   = 3'd0;
   localparam logic [2:0] OP_RELEASE = 3'd1;
   localparam logic [2:0] OP_PULSE   = 3'd2;
   localparam logic [2:0] OP_RD_PINS = 3'd3;
   localparam logic [2:0] OP_RD_OUTS = 3'd4;
   localparam logic [2:0] OP_RD_EDGE = 3'd5;

   state_t                state_q, state_d;
   logic [2:0]            op_q, op_d;
   logic                  err_q, err_d;
   logic [CELL_COUNT-1:0] set_q, set_d;
   logic [CELL_COUNT-1:0] clr_q, clr_d;
   logic [CELL_COUNT-1:0] pls_q, pls_d;
   logic [9:0]            din_q, din_d;
   logic                  rvalid_q, rvalid_d;
   logic [15:0]           rdata_q, rdata_d;
   logic                  rerr_q, rerr_d;
   logic [CELL_COUNT-1:0] hist_q, hist_d;
   logic [CELL_COUNT-1:0] edge_q, edge_d;

   logic [INDEX_W-1:0]    idx;
   logic [CELL_COUNT-1:0] onehot;
   logic [CELL_COUNT-1:0] rise;
   logic                  idx_oob;
   logic                  cmd_err;

   assign idx     = bus.CmdIndex;
   assign onehot  = CELL_COUNT'(1) << idx;
   assign rise    = ~hist_q & CellPinDataOut;
   assign idx_oob = (32'(idx) >= CELL_COUNT);

   // Reject reserved ops, out-of-range cells and zero-length pulses.
   always_comb begin
      cmd_err = 1'b0;
      case (bus.CmdOp)
         OP_DRIVE, OP_RELEASE: cmd_err = idx_oob;
         OP_PULSE:   cmd_err = idx_oob || (bus.CmdData == 10'd0);
         OP_RD_PINS, OP_RD_OUTS, OP_RD_EDGE: cmd_err = 1'b0;
         default:    cmd_err = 1'b1;
      endcase
   end

   // Next-state logic; nothing moves unless clk_en is high.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      err_d    = err_q;
      set_d    = set_q;
      clr_d    = clr_q;
      pls_d    = pls_q;
      din_d    = din_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rerr_d   = rerr_q;
      hist_d   = hist_q;
      edge_d   = edge_q;
      if (clk_en) begin
         hist_d = CellPinDataOut;
         edge_d = edge_q | rise;
         unique case (state_q)
            IDLE: begin
               if (bus.CmdValid) begin
                  state_d = ISSUE;
                  op_d    = bus.CmdOp;
                  err_d   = cmd_err;
                  if (!cmd_err) begin
                     case (bus.CmdOp)
                        OP_DRIVE: begin
                           set_d = onehot;
                           din_d = {9'b0, bus.CmdData[0]};
                        end
                        OP_RELEASE: clr_d = onehot;
                        OP_PULSE: begin
                           pls_d = onehot;
                           din_d = bus.CmdData;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            ISSUE: begin
               state_d  = RESP;
               set_d    = '0;
               clr_d    = '0;
               pls_d    = '0;
               rvalid_d = 1'b1;
               rerr_d   = err_q;
               rdata_d  = 16'd0;
               if (!err_q) begin
                  case (op_q)
                     OP_RD_PINS: rdata_d = 16'(CellPinDataOut);
                     OP_RD_OUTS: rdata_d = 16'(CellLocalDataOut);
                     OP_RD_EDGE: begin
                        rdata_d = 16'(edge_q);
                        edge_d  = rise;
                     end
                     default: ;
                  endcase
               end
            end
            RESP: begin
               if (bus.RespReady) begin
                  state_d  = IDLE;
                  rvalid_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and registered outputs; reset overrides clk_en.
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state_q  <= IDLE;
         op_q     <= 3'd0;
         err_q    <= 1'b0;
         set_q    <= '0;
         clr_q    <= '0;
         pls_q    <= '0;
         din_q    <= 10'd0;
         rvalid_q <= 1'b0;
         rdata_q  <= 16'd0;
         rerr_q   <= 1'b0;
         hist_q   <= '0;
         edge_q   <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         err_q    <= err_d;
         set_q    <= set_d;
         clr_q    <= clr_d;
         pls_q    <= pls_d;
         din_q    <= din_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rerr_q   <= rerr_d;
         hist_q   <= hist_d;
         edge_q   <= edge_d;
      end
   end

   assign bus.CmdReady  = (state_q == IDLE) && !sync_rst;
   assign bus.RespValid = rvalid_q;
   assign bus.RespData  = rdata_q;
   assign bus.RespErr   = rerr_q;
   assign CellSet       = set_q;
   assign CellClear     = clr_q;
   assign CellPulseInit = pls_q;
   assign CellDataIn    = din_q;

endmodule

// File: tb/tb_gpio_port_controller.sv
// Self-checking bench for gpio_port_controller.
// Directed scenarios plus randomized commands against a behavioural model.
module tb_gpio_port_controller;

   logic       clk = 1'b0;
   logic       sync_rst;
   logic       clk_en;
   logic [7:0] set, clr, pls;
   logic [9:0] din;
   logic [7:0] outs, pins;

   always #5 clk = ~clk;

   gpio_port_controller_if #(.INDEX_W(4)) bus ();

   gpio_port_controller #(.CELL_COUNT(8), .INDEX_W(4)) dut (
      .clk(clk),
      .sync_rst(sync_rst),
      .clk_en(clk_en),
      .bus(bus),
      .CellSet(set),
      .CellClear(clr),
      .CellPulseInit(pls),
      .CellDataIn(din),
      .CellLocalDataOut(outs),
      .CellPinDataOut(pins)
   );

   int n_tot = 0;
   int n_pass = 0;

   logic [7:0]  m_pins, m_edge;
   logic [9:0]  m_din;
   logic        ip_en;
   logic [7:0]  ip_val;

   logic [7:0]  e_set, e_clr, e_pls;
   logic [15:0] e_rd;
   logic        e_err;

   logic [7:0]  obs_set, obs_clr, obs_pls;
   int          obs_scyc;
   logic [9:0]  obs_din;
   logic [15:0] obs_rd;
   logic        obs_err, obs_ok, obs_stable, obs_rdy_low;
   logic        obs_rv_after, obs_rdy_after;

   task automatic model(input logic [2:0] op, input logic [3:0] idx,
                        input logic [9:0] data);
      logic [7:0] nw;
      e_set = 0; e_clr = 0; e_pls = 0; e_rd = 0;
      e_err = (op >= 3'd6) || (op <= 3'd2 && idx >= 4'd8) ||
              (op == 3'd2 && data == 10'd0);
      nw = ip_en ? (ip_val & ~m_pins) : 8'h00;
      if (!e_err) begin
         case (op)
            3'd0: begin e_set = 8'(1) << idx; m_din = {9'b0, data[0]}; end
            3'd1: e_clr = 8'(1) << idx;
            3'd2: begin e_pls = 8'(1) << idx; m_din = data; end
            3'd3: e_rd = {8'h00, m_pins};
            3'd4: e_rd = {8'h00, outs};
            default: begin e_rd = {8'h00, m_edge}; m_edge = 8'h00; end
         endcase
      end
      m_edge = m_edge | nw;
      if (ip_en) m_pins = ip_val;
   endtask

   task automatic set_pins(input logic [7:0] v);
      pins = v; clk_en = 1'b1;
      @(posedge clk); #1;
      m_edge = m_edge | (v & ~m_pins);
      m_pins = v;
   endtask

   task automatic do_cmd(input logic [2:0] op, input logic [3:0] idx,
                         input logic [9:0] data, input int hold,
                         input bit en_rand);
      int n;
      logic [7:0]  s;
      logic [15:0] d0;
      logic        e0;
      obs_set = 0; obs_clr = 0; obs_pls = 0; obs_scyc = 0; obs_din = din;
      obs_ok = 1; obs_stable = 1; obs_rdy_low = 1;
      obs_rd = 16'hxxxx; obs_err = 1'bx;
      clk_en = 1'b1;
      bus.CmdOp = op; bus.CmdIndex = idx; bus.CmdData = data;
      bus.CmdValid = 1'b1;
      n = 0;
      while (bus.CmdReady !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) begin obs_ok = 0; bus.CmdValid = 1'b0; return; end
      @(posedge clk); #1;
      bus.CmdValid = 1'b0;
      if (ip_en) pins = ip_val;
      n = 0;
      while (bus.RespValid !== 1'b1 && n < 50) begin
         s = set | clr | pls;
         obs_set |= set; obs_clr |= clr; obs_pls |= pls;
         if (s != 0) obs_din = din;
         if (bus.CmdReady) obs_rdy_low = 0;
         if (en_rand) clk_en = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         if (s != 0 && clk_en) obs_scyc++;
         @(posedge clk); #1; n++;
      end
      if (n >= 50) begin obs_ok = 0; clk_en = 1'b1; return; end
      d0 = bus.RespData; e0 = bus.RespErr;
      for (int i = 0; i < hold; i++) begin
         if (en_rand) clk_en = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if (bus.RespData !== d0 || bus.RespErr !== e0 ||
             bus.RespValid !== 1'b1) obs_stable = 0;
         obs_set |= set; obs_clr |= clr; obs_pls |= pls;
         if ((set | clr | pls) != 0) obs_scyc++;
         if (bus.CmdReady) obs_rdy_low = 0;
      end
      obs_rd = d0; obs_err = e0;
      clk_en = 1'b1; bus.RespReady = 1'b1;
      @(posedge clk); #1;
      bus.RespReady = 1'b0;
      obs_rv_after = bus.RespValid;
      obs_rdy_after = bus.CmdReady;
   endtask

   task automatic test_reset;
      sync_rst = 1'b1; clk_en = 1'b0;
      bus.CmdValid = 0; bus.CmdOp = 0; bus.CmdIndex = 0; bus.CmdData = 0;
      bus.RespReady = 0; pins = 0; outs = 0;
      repeat (3) @(posedge clk);
      #1;
      n_tot++; if (bus.CmdReady !== 1'b0) $display("FAIL rst_ready act=%b exp=0", bus.CmdReady); else n_pass++;
      n_tot++; if (bus.RespValid !== 1'b0) $display("FAIL rst_rvalid act=%b exp=0", bus.RespValid); else n_pass++;
      n_tot++; if ({bus.RespErr, bus.RespData} !== 17'd0) $display("FAIL rst_resp act=%h exp=0", {bus.RespErr, bus.RespData}); else n_pass++;
      n_tot++; if ({set, clr, pls} !== 24'd0) $display("FAIL rst_strobes act=%h exp=0", {set, clr, pls}); else n_pass++;
      n_tot++; if (din !== 10'd0) $display("FAIL rst_din act=%h exp=0", din); else n_pass++;
      sync_rst = 1'b0; #1;
      n_tot++; if (bus.CmdReady !== 1'b1) $display("FAIL rst_ready_after act=%b exp=1", bus.CmdReady); else n_pass++;
      clk_en = 1'b1;
      @(posedge clk); #1;
      m_din = 0; m_pins = pins; m_edge = pins;
   endtask

   task automatic test_drive;
      model(3'd0, 4'd3, 10'd1);
      do_cmd(3'd0, 4'd3, 10'd1, 2, 0);
      n_tot++; if (obs_ok !== 1'b1) $display("FAIL drv_timeout act=%b exp=1", obs_ok); else n_pass++;
      n_tot++; if (obs_set !== 8'h08) $display("FAIL drv_set act=%h exp=08", obs_set); else n_pass++;
      n_tot++; if ({obs_clr, obs_pls} !== 16'h0) $display("FAIL drv_other act=%h exp=0", {obs_clr, obs_pls}); else n_pass++;
      n_tot++; if (obs_scyc != 1) $display("FAIL drv_width act=%0d exp=1", obs_scyc); else n_pass++;
      n_tot++; if (obs_din !== 10'h001) $display("FAIL drv_din act=%h exp=001", obs_din); else n_pass++;
      n_tot++; if ({obs_err, obs_rd} !== 17'd0) $display("FAIL drv_resp act=%h exp=0", {obs_err, obs_rd}); else n_pass++;
      n_tot++; if (obs_rdy_low !== 1'b1) $display("FAIL drv_ready_low act=%b exp=1", obs_rdy_low); else n_pass++;
      n_tot++; if ({obs_rv_after, obs_rdy_after} !== 2'b01) $display("FAIL drv_after act=%b exp=01", {obs_rv_after, obs_rdy_after}); else n_pass++;
   endtask

   task automatic test_back_to_back;
      model(3'd2, 4'd0, 10'd5);
      do_cmd(3'd2, 4'd0, 10'd5, 0, 0);
      n_tot++; if (obs_pls !== e_pls || e_pls !== 8'h01) $display("FAIL b2b_pulse act=%h exp=%h", obs_pls, e_pls); else n_pass++;
      n_tot++; if (obs_din !== m_din) $display("FAIL b2b_din act=%h exp=%h", obs_din, m_din); else n_pass++;
      n_tot++; if (obs_ok !== 1'b1 || obs_err !== 1'b0) $display("FAIL b2b_resp1 act=%b%b exp=10", obs_ok, obs_err); else n_pass++;
      model(3'd1, 4'd7, 10'd0);
      do_cmd(3'd1, 4'd7, 10'd0, 0, 0);
      n_tot++; if (obs_clr !== 8'h80 || obs_set !== 0 || obs_pls !== 0) $display("FAIL b2b_clear act=%h exp=80", obs_clr); else n_pass++;
      n_tot++; if (obs_ok !== 1'b1 || obs_err !== 1'b0) $display("FAIL b2b_resp2 act=%b%b exp=10", obs_ok, obs_err); else n_pass++;
      n_tot++; if (din !== 10'd5) $display("FAIL b2b_din_hold act=%h exp=005", din); else n_pass++;
   endtask

   task automatic test_errors;
      logic [2:0] ops [5];
      logic [3:0] ids [5];
      logic [9:0] dts [5];
      ops = '{3'd0, 3'd6, 3'd2, 3'd7, 3'd1};
      ids = '{4'd9, 4'd1, 4'd2, 4'd0, 4'd8};
      dts = '{10'd1, 10'd3, 10'd0, 10'd1, 10'd0};
      for (int k = 0; k < 5; k++) begin
         model(ops[k], ids[k], dts[k]);
         do_cmd(ops[k], ids[k], dts[k], 1, 0);
         n_tot++; if (obs_err !== 1'b1 || obs_rd !== 16'd0) $display("FAIL err_resp%0d act=%b/%h exp=1/0000", k, obs_err, obs_rd); else n_pass++;
         n_tot++; if ({obs_set, obs_clr, obs_pls} !== 24'd0) $display("FAIL err_strobe%0d act=%h exp=0", k, {obs_set, obs_clr, obs_pls}); else n_pass++;
      end
      n_tot++; if (din !== m_din) $display("FAIL err_din act=%h exp=%h", din, m_din); else n_pass++;
   endtask

   task automatic test_edges;
      model(3'd5, 0, 0); do_cmd(3'd5, 0, 0, 0, 0);
      set_pins(8'h00);
      set_pins(8'h05);
      model(3'd5, 0, 0); do_cmd(3'd5, 0, 0, 0, 0);
      n_tot++; if (obs_rd !== 16'h0005 || e_rd !== 16'h0005) $display("FAIL edge_first act=%h exp=0005", obs_rd); else n_pass++;
      model(3'd5, 0, 0); do_cmd(3'd5, 0, 0, 0, 0);
      n_tot++; if (obs_rd !== 16'h0000) $display("FAIL edge_cleared act=%h exp=0000", obs_rd); else n_pass++;
      set_pins(8'h15);
      ip_en = 1'b1; ip_val = 8'h17;
      model(3'd5, 0, 0); do_cmd(3'd5, 0, 0, 0, 0);
      ip_en = 1'b0;
      n_tot++; if (obs_rd !== 16'h0010) $display("FAIL edge_clear_race act=%h exp=0010", obs_rd); else n_pass++;
      model(3'd5, 0, 0); do_cmd(3'd5, 0, 0, 0, 0);
      n_tot++; if (obs_rd !== 16'h0002) $display("FAIL edge_new_wins act=%h exp=0002", obs_rd); else n_pass++;
      model(3'd3, 0, 0); do_cmd(3'd3, 0, 0, 0, 0);
      n_tot++; if (obs_rd !== e_rd) $display("FAIL read_pins act=%h exp=%h", obs_rd, e_rd); else n_pass++;
   endtask

   task automatic test_stall;
      model(3'd0, 4'd5, 10'd1);
      do_cmd(3'd0, 4'd5, 10'd1, 10, 1);
      n_tot++; if (obs_ok !== 1'b1) $display("FAIL stall_timeout act=%b exp=1", obs_ok); else n_pass++;
      n_tot++; if (obs_set !== e_set) $display("FAIL stall_set act=%h exp=%h", obs_set, e_set); else n_pass++;
      n_tot++; if (obs_scyc != 1) $display("FAIL stall_width act=%0d exp=1", obs_scyc); else n_pass++;
      n_tot++; if (obs_stable !== 1'b1) $display("FAIL stall_resp_stable act=%b exp=1", obs_stable); else n_pass++;
      n_tot++; if (obs_rdy_low !== 1'b1) $display("FAIL stall_ready_low act=%b exp=1", obs_rdy_low); else n_pass++;
      outs = 8'hA6;
      model(3'd4, 0, 0); do_cmd(3'd4, 0, 0, 10, 1);
      n_tot++; if (obs_rd !== e_rd || obs_stable !== 1'b1) $display("FAIL stall_read_outs act=%h exp=%h", obs_rd, e_rd); else n_pass++;
   endtask

   task automatic test_reset_mid;
      set_pins(8'h08);
      set_pins(8'h00);
      clk_en = 1'b1;
      bus.CmdOp = 3'd0; bus.CmdIndex = 4'd2; bus.CmdData = 10'd1;
      bus.CmdValid = 1'b1;
      @(posedge clk); #1;
      bus.CmdValid = 1'b0;
      n_tot++; if (set !== 8'h04) $display("FAIL mid_issue_set act=%h exp=04", set); else n_pass++;
      sync_rst = 1'b1;
      @(posedge clk); #1;
      n_tot++; if ({set, clr, pls} !== 24'd0 || bus.RespValid !== 1'b0) $display("FAIL mid_issue_rst act=%h/%b exp=0/0", {set, clr, pls}, bus.RespValid); else n_pass++;
      n_tot++; if (din !== 10'd0) $display("FAIL mid_issue_din act=%h exp=0", din); else n_pass++;
      sync_rst = 1'b0; #1;
      n_tot++; if (bus.CmdReady !== 1'b1) $display("FAIL mid_ready act=%b exp=1", bus.CmdReady); else n_pass++;
      m_din = 0; m_edge = m_pins;
      @(posedge clk); #1;
      model(3'd5, 0, 0); do_cmd(3'd5, 0, 0, 0, 0);
      n_tot++; if (obs_rd !== 16'h0000) $display("FAIL mid_edges act=%h exp=0000", obs_rd); else n_pass++;
      bus.CmdOp = 3'd3; bus.CmdValid = 1'b1;
      @(posedge clk); #1;
      bus.CmdValid = 1'b0;
      @(posedge clk); #1;
      n_tot++; if (bus.RespValid !== 1'b1) $display("FAIL mid_resp_up act=%b exp=1", bus.RespValid); else n_pass++;
      sync_rst = 1'b1;
      @(posedge clk); #1;
      n_tot++; if (bus.RespValid !== 1'b0 || bus.RespData !== 16'd0) $display("FAIL mid_resp_rst act=%b/%h exp=0/0", bus.RespValid, bus.RespData); else n_pass++;
      sync_rst = 1'b0;
      m_din = 0; m_edge = m_pins;
      @(posedge clk); #1;
      n_tot++; if (bus.CmdReady !== 1'b1 || bus.RespValid !== 1'b0) $display("FAIL mid_recover act=%b%b exp=10", bus.CmdReady, bus.RespValid); else n_pass++;
   endtask

   task automatic test_random;
      logic [2:0] op;
      logic [3:0] idx;
      logic [9:0] data;
      int         errs;
      errs = 0;
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 2) == 0) set_pins(8'($urandom));
         outs = 8'($urandom);
         op = 3'($urandom_range(0, 7));
         idx = 4'($urandom_range(0, 9));
         data = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom);
         model(op, idx, data);
         do_cmd(op, idx, data, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         n_tot++;
         if (obs_ok !== 1'b1 || obs_set !== e_set || obs_clr !== e_clr ||
             obs_pls !== e_pls || obs_rd !== e_rd || obs_err !== e_err ||
             obs_din !== m_din || obs_stable !== 1'b1 ||
             obs_scyc != ((e_set | e_clr | e_pls) != 0 ? 1 : 0)) begin
            errs++;
            $display("FAIL rand%0d op=%0d idx=%0d act=%h/%h/%h/%h/%b/%h/%0d exp=%h/%h/%h/%h/%b/%h",
                     k, op, idx, obs_set, obs_clr, obs_pls, obs_rd, obs_err,
                     obs_din, obs_scyc, e_set, e_clr, e_pls, e_rd, e_err, m_din);
         end else n_pass++;
      end
      n_tot++; if (din !== m_din) $display("FAIL rand_din_final act=%h exp=%h", din, m_din); else n_pass++;
   endtask

   initial begin
      ip_en = 1'b0; ip_val = 8'h00;
      m_pins = 0; m_edge = 0; m_din = 0;
      test_reset;
      test_drive;
      test_back_to_back;
      test_errors;
      test_edges;
      test_stall;
      test_reset_mid;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
